// File: rtl/rfid_pkg.sv
// Shared types and sizing helpers for the RFID access controller.
package rfid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_UNLOCK,
    S_REJECT,
    S_LOCKOUT
  } state_t;

  localparam int TOKEN_W = 64;
  localparam int BYTES_PER_TOKEN = 8;

  function automatic int cnt_w(input longint unsigned v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/rfid_bus_sync.sv
// ESP32 bus synchronisers: byte strobe edge detect, data capture
// and frame-start latch into the CLOCK_50 domain.
module rfid_bus_sync (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] bus_data,
  input  logic       bus_clk,
  input  logic       bus_latch,
  output logic       byte_stb,
  output logic [7:0] byte_q,
  output logic       latch_s
);

  logic [2:0] clk_sr;
  logic [1:0] lat_sr;
  logic       rise;

  assign rise    = clk_sr[1] & ~clk_sr[2];
  assign latch_s = lat_sr[1];

  // bus_data is held stable while bus_clk is high, so no sync needed
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sr   <= '0;
      lat_sr   <= '0;
      byte_stb <= 1'b0;
      byte_q   <= '0;
    end else begin
      clk_sr   <= {clk_sr[1:0], bus_clk};
      lat_sr   <= {lat_sr[0], bus_latch};
      byte_stb <= rise;
      if (rise) byte_q <= bus_data;
    end
  end

endmodule

// File: rtl/rfid_access_ctrl.sv
// RFID token receiver with replay history, unlock pulse sequencing,
// frame timeout and replay lockout.
module rfid_access_ctrl
  import rfid_pkg::*;
#(
  parameter int HIST_DEPTH     = 4,
  parameter int UNLOCK_CYCLES  = 50000000,
  parameter int BYTE_TIMEOUT   = 500000,
  parameter int LOCKOUT_THRESH = 3,
  parameter int LOCKOUT_CYCLES = 250000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] bus_data,
  input  logic       bus_clk,
  input  logic       bus_latch,
  output logic       unlock_out,
  output logic       replay_out,
  output logic       lockout_out,
  output logic       error_out
);

  localparam int T_UL = (UNLOCK_CYCLES > BYTE_TIMEOUT)
                      ? UNLOCK_CYCLES : BYTE_TIMEOUT;
  localparam int TMAX = (LOCKOUT_CYCLES > T_UL)
                      ? LOCKOUT_CYCLES : T_UL;
  localparam int TW = cnt_w(TMAX);
  localparam int IW = $clog2(HIST_DEPTH);
  localparam int RW = cnt_w(LOCKOUT_THRESH);

  logic               byte_stb;
  logic [7:0]         byte_q;
  logic               latch_s;

  state_t             state_q, state_n;
  logic [TOKEN_W-1:0] tok_q, tok_n;
  logic [3:0]         bcnt_q, bcnt_n;
  logic [TW-1:0]      tmr_q, tmr_n;
  logic [IW-1:0]      idx_q, idx_n;
  logic [IW-1:0]      wptr_q, wptr_n;
  logic               match_q, match_n;
  logic [RW-1:0]      rcnt_q, rcnt_n;
  logic [HIST_DEPTH-1:0] hval_q, hval_n;
  logic [TOKEN_W-1:0] hist [HIST_DEPTH];
  logic               hwe;
  logic               hit;
  logic               err_n;

  rfid_bus_sync u_sync (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus_data (bus_data),
    .bus_clk  (bus_clk),
    .bus_latch(bus_latch),
    .byte_stb (byte_stb),
    .byte_q   (byte_q),
    .latch_s  (latch_s)
  );

  assign hit = hval_q[idx_q] && (hist[idx_q] == tok_q);

  always_comb begin
    state_n = state_q;
    tok_n   = tok_q;
    bcnt_n  = bcnt_q;
    tmr_n   = tmr_q;
    idx_n   = idx_q;
    wptr_n  = wptr_q;
    match_n = match_q;
    rcnt_n  = rcnt_q;
    hval_n  = hval_q;
    hwe     = 1'b0;
    err_n   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (latch_s) begin
          tok_n  = '0;
          bcnt_n = '0;
        end else if (byte_stb) begin
          tok_n   = {tok_q[TOKEN_W-9:0], byte_q};
          bcnt_n  = 4'd1;
          tmr_n   = TW'(BYTE_TIMEOUT - 1);
          state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (latch_s) begin
          tok_n   = '0;
          bcnt_n  = '0;
          state_n = S_IDLE;
        end else if (byte_stb) begin
          tok_n  = {tok_q[TOKEN_W-9:0], byte_q};
          bcnt_n = bcnt_q + 4'd1;
          tmr_n  = TW'(BYTE_TIMEOUT - 1);
          if (bcnt_q == 4'(BYTES_PER_TOKEN - 1)) begin
            idx_n   = '0;
            match_n = 1'b0;
            state_n = S_CHECK;
          end
        end else if (tmr_q == '0) begin
          err_n   = 1'b1;
          tok_n   = '0;
          bcnt_n  = '0;
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr_q - 1'b1;
        end
      end
      S_CHECK: begin
        match_n = match_q | hit;
        idx_n   = idx_q + 1'b1;
        if (idx_q == IW'(HIST_DEPTH - 1)) begin
          bcnt_n = '0;
          if (match_q | hit) begin
            state_n = S_REJECT;
          end else begin
            hwe            = 1'b1;
            hval_n[wptr_q] = 1'b1;
            wptr_n         = wptr_q + 1'b1;
            rcnt_n         = '0;
            tmr_n          = TW'(UNLOCK_CYCLES - 1);
            state_n        = S_UNLOCK;
          end
        end
      end
      S_UNLOCK, S_LOCKOUT: begin
        if (tmr_q == '0) state_n = S_IDLE;
        else tmr_n = tmr_q - 1'b1;
      end
      S_REJECT: begin
        if (rcnt_q + 1'b1 == RW'(LOCKOUT_THRESH)) begin
          rcnt_n  = '0;
          tmr_n   = TW'(LOCKOUT_CYCLES - 1);
          state_n = S_LOCKOUT;
        end else begin
          rcnt_n  = rcnt_q + 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Bytes arriving while busy are discarded and flagged
    if (byte_stb && state_q != S_IDLE && state_q != S_RECV)
      err_n = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tok_q       <= '0;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      idx_q       <= '0;
      wptr_q      <= '0;
      match_q     <= 1'b0;
      rcnt_q      <= '0;
      hval_q      <= '0;
      unlock_out  <= 1'b0;
      replay_out  <= 1'b0;
      lockout_out <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      state_q     <= state_n;
      tok_q       <= tok_n;
      bcnt_q      <= bcnt_n;
      tmr_q       <= tmr_n;
      idx_q       <= idx_n;
      wptr_q      <= wptr_n;
      match_q     <= match_n;
      rcnt_q      <= rcnt_n;
      hval_q      <= hval_n;
      unlock_out  <= (state_n == S_UNLOCK);
      replay_out  <= (state_n == S_REJECT);
      lockout_out <= (state_n == S_LOCKOUT);
      error_out   <= err_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (hwe) hist[wptr_q] <= tok_q;
  end

endmodule

// File: tb/tb_rfid_access_ctrl.sv
// Randomised scoreboard bench for rfid_access_ctrl.
// Expected pulses are queued by the driver and matched by a monitor.
module tb_rfid_access_ctrl;

  localparam int D   = 4;
  localparam int U   = 20;
  localparam int L   = 40;
  localparam int B   = 30;
  localparam int THR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus_data = '0;
  logic       bus_clk = 1'b0;
  logic       bus_latch = 1'b0;
  logic       unlock_out, replay_out, lockout_out, error_out;

  rfid_access_ctrl #(
    .HIST_DEPTH    (D),
    .UNLOCK_CYCLES (U),
    .BYTE_TIMEOUT  (B),
    .LOCKOUT_THRESH(THR),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .bus_data   (bus_data),
    .bus_clk    (bus_clk),
    .bus_latch  (bus_latch),
    .unlock_out (unlock_out),
    .replay_out (replay_out),
    .lockout_out(lockout_out),
    .error_out  (error_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 unlock, 1 replay, 2 lockout, 3 error
  typedef struct {
    int kind;
    int at;
    int width;
  } ev_t;

  ev_t evq[$];
  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] hist_m[$];
  logic [63:0] frame = '0;
  int fcnt = 0;
  int last_pin = 0;
  int busy_last = 0;
  int rcnt_m = 0;
  int rst_offset = 0;
  int reset_at = 1 << 30;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void expect_ev(input int k, input int at,
                                    input int w);
    ev_t e;
    e.kind  = k;
    e.at    = at;
    e.width = w;
    evq.push_back(e);
  endfunction

  // Reference: decision is visible D+4 cycles after the 8th pin edge
  function automatic void model_token(input int n);
    int s;
    int w;
    bit hit;
    s = n + 4 + D;
    hit = 1'b0;
    foreach (hist_m[i]) if (hist_m[i] == frame) hit = 1'b1;
    if (hit) begin
      rcnt_m++;
      expect_ev(1, s, 1);
      if (rcnt_m == THR) begin
        rcnt_m = 0;
        expect_ev(2, s + 1, L);
        busy_last = s + 1 + L;
      end else begin
        busy_last = s + 1;
      end
    end else begin
      w = U;
      if (rst_offset > 0) begin
        reset_at = s + rst_offset;
        w = rst_offset + 1;
      end
      expect_ev(0, s, w);
      busy_last = s + U;
      hist_m.push_back(frame);
      if (hist_m.size() > D) void'(hist_m.pop_front());
      rcnt_m = 0;
    end
    frame = '0;
    fcnt = 0;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus_data = b;
    bus_clk = 1'b1;
    n = cyc;
    if (n + 4 <= busy_last) begin
      expect_ev(3, n + 4, 1);
    end else begin
      frame = {frame[55:0], b};
      fcnt++;
      last_pin = n;
      if (fcnt == 8) model_token(n);
    end
    repeat (4) @(negedge clk);
    bus_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_token(input logic [63:0] t);
    for (int i = 7; i >= 0; i--) send_byte(t[i*8 +: 8]);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_latch();
    @(negedge clk);
    bus_latch = 1'b1;
    repeat (4) @(negedge clk);
    bus_latch = 1'b0;
    repeat (4) @(negedge clk);
    frame = '0;
    fcnt = 0;
  endtask

  task automatic model_timeout();
    expect_ev(3, last_pin + 4 + B, 1);
    frame = '0;
    fcnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hist_m.delete();
    rcnt_m = 0;
    frame = '0;
    fcnt = 0;
    busy_last = 0;
    reset_at = 1 << 30;
    rst_offset = 0;
    @(negedge clk);
    check("unlock_after_reset", unlock_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: pops expectations as outputs rise, checks widths on fall
  string nm[4] = '{"unlock", "replay", "lockout", "error"};
  logic [3:0] prev = '0;
  int st[4];
  int wexp[4];
  always @(negedge clk) begin
    logic [3:0] o;
    int idx;
    o = {error_out, lockout_out, replay_out, unlock_out};
    for (int k = 0; k < 4; k++) begin
      if (o[k] === 1'b1 && prev[k] == 1'b0) begin
        idx = -1;
        for (int i = 0; i < evq.size(); i++)
          if (idx < 0 && evq[i].kind == k) idx = i;
        if (idx < 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL %s_unexpected: pulse at cycle %0d, none expected",
                   nm[k], cyc);
          wexp[k] = 0;
        end else begin
          check({nm[k], "_start"}, cyc, evq[idx].at);
          wexp[k] = evq[idx].width;
          evq.delete(idx);
        end
        st[k] = cyc;
      end else if (o[k] !== 1'b1 && prev[k] == 1'b1 && wexp[k] > 0) begin
        check({nm[k], "_width"}, cyc - st[k], wexp[k]);
      end
      prev[k] = (o[k] === 1'b1);
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: cycle %0d, limit reached", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] t1, tx;
    logic [63:0] tk[5];
    logic [63:0] pool[$];
    t1 = 64'h0123456789ABCDEF;

    repeat (3) @(negedge clk);
    check("rst_unlock", unlock_out, 0);
    check("rst_replay", replay_out, 0);
    check("rst_lockout", lockout_out, 0);
    check("rst_error", error_out, 0);
    reset = 1'b0;
    idle(4);

    // First accept, then three replays ending in lockout
    send_token(t1);
    idle(50);
    for (int r = 0; r < 3; r++) begin
      send_token(t1);
      if (r < 2) idle(50);
    end
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()));
    idle(60);

    // FIFO eviction of the oldest history entry
    for (int i = 0; i < 5; i++) begin
      tk[i] = rnd64();
      send_token(tk[i]);
      idle(50);
    end
    send_token(tk[0]);
    idle(50);
    send_token(tk[4]);
    idle(50);

    // Partial frame expires, then a clean frame
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()));
    model_timeout();
    idle(45);
    send_token(rnd64());
    idle(50);

    // Frame-start marker discards a partial frame
    for (int i = 0; i < 5; i++) send_byte(8'($urandom()));
    pulse_latch();
    send_token(64'hFEDCBA9876543210);
    idle(50);
    send_token(64'hFEDCBA9876543210);
    idle(50);

    // Reset mid-UNLOCK, then mid-RECV; history must be empty after
    tx = rnd64();
    rst_offset = 5;
    send_token(tx);
    while (cyc < reset_at) @(negedge clk);
    do_reset();
    idle(4);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()));
    do_reset();
    idle(4);
    send_token(tx);
    idle(50);

    // Random mix of fresh and repeated tokens
    for (int i = 0; i < 12; i++) begin
      if (pool.size() > 0 && ($urandom() % 2) == 0) begin
        tx = pool[$urandom_range(0, pool.size() - 1)];
      end else begin
        tx = rnd64();
        pool.push_back(tx);
      end
      send_token(tx);
      idle(55);
    end

    idle(10);
    check("queue_drained", evq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
